// File: rtl/psram_arbiter.sv
// Two-port byte arbiter for a single PSRAM: CPU bus has priority, MCU/SPI port is
// protected by a starvation counter. Each access is a timed CE/OE/WE cycle plus recovery.
module psram_arbiter #(
    parameter int unsigned ACC_CYC = 6,
    parameter int unsigned REC_CYC = 2,
    parameter int unsigned STARVE  = 4,
    parameter int unsigned ADDR_W  = 24
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_dati_i,
    output logic [7:0]        cpu_dato_o,
    output logic              cpu_ack_o,
    input  logic              mcu_req_i,
    input  logic              mcu_we_i,
    input  logic [ADDR_W-1:0] mcu_addr_i,
    input  logic [7:0]        mcu_dati_i,
    output logic [7:0]        mcu_dato_o,
    output logic              mcu_ack_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_dati_o,
    input  logic [7:0]        mem_dato_i,
    output logic              mem_ce_o,
    output logic              mem_oe_o,
    output logic              mem_we_o,
    output logic              busy_o
);

    localparam int unsigned CntW = $clog2(ACC_CYC + REC_CYC);
    localparam int unsigned StW  = $clog2(STARVE + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [StW-1:0]    starve_q;
    logic              owner_mcu_q;
    logic              wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_dati_q;
    logic              mem_ce_q, mem_oe_q, mem_we_q, busy_q;
    logic              cpu_ack_q, mcu_ack_q;
    logic [7:0]        cpu_dato_q, mcu_dato_q;

    logic starve_hit, grant_mcu, sel_we;

    // CPU wins unless the MCU has been passed over STARVE times in a row.
    assign starve_hit = mcu_req_i && (starve_q == StW'(STARVE));
    assign grant_mcu  = mcu_req_i && !(cpu_req_i && !starve_hit);
    assign sel_we     = grant_mcu ? mcu_we_i : cpu_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_mcu_q <= 1'b0;
            wr_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_dati_q  <= '0;
            mem_ce_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            mcu_ack_q   <= 1'b0;
            cpu_dato_q  <= '0;
            mcu_dato_q  <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            mcu_ack_q <= 1'b0;
            if (!mcu_req_i) starve_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_req_i || mcu_req_i) begin
                        owner_mcu_q <= grant_mcu;
                        wr_q        <= sel_we;
                        mem_addr_q  <= grant_mcu ? mcu_addr_i : cpu_addr_i;
                        mem_dati_q  <= grant_mcu ? mcu_dati_i : cpu_dati_i;
                        mem_ce_q    <= 1'b1;
                        mem_oe_q    <= !sel_we;
                        mem_we_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StAccess;
                        if (grant_mcu) begin
                            starve_q <= '0;
                        end else if (mcu_req_i && !starve_hit) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q == CntW'(ACC_CYC - 1)) begin
                        mem_ce_q  <= 1'b0;
                        mem_oe_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        cpu_ack_q <= !owner_mcu_q;
                        mcu_ack_q <= owner_mcu_q;
                        if (!wr_q && !owner_mcu_q) cpu_dato_q <= mem_dato_i;
                        if (!wr_q && owner_mcu_q)  mcu_dato_q <= mem_dato_i;
                        cnt_q     <= '0;
                        state_q   <= StRecover;
                    end else begin
                        // WE is kept off the first and last CE clock for setup/hold.
                        cnt_q    <= cnt_q + 1'b1;
                        mem_we_q <= wr_q && ((cnt_q + 1'b1) <= CntW'(ACC_CYC - 2));
                    end
                end
                StRecover: begin
                    if (cnt_q == CntW'(REC_CYC - 1)) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_dati_o = mem_dati_q;
    assign mem_ce_o   = mem_ce_q;
    assign mem_oe_o   = mem_oe_q;
    assign mem_we_o   = mem_we_q;
    assign busy_o     = busy_q;
    assign cpu_ack_o  = cpu_ack_q;
    assign mcu_ack_o  = mcu_ack_q;
    assign cpu_dato_o = cpu_dato_q;
    assign mcu_dato_o = mcu_dato_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: timestamp-based reference model checked every clock,
// plus directed scenarios for ordering, starvation, reset abort and early req drop.
module tb_psram_arbiter;

    localparam int ACC = 6;
    localparam int REC = 2;
    localparam int STV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, mcu_req = 1'b0, mcu_we = 1'b0;
    logic [23:0] cpu_addr = '0, mcu_addr = '0;
    logic [7:0]  cpu_dati = '0, mcu_dati = '0;
    logic [7:0]  cpu_dato, mcu_dato, mem_dati, mem_dato;
    logic        cpu_ack, mcu_ack, mem_ce, mem_oe, mem_we, busy;
    logic [23:0] mem_addr;

    int total = 0;
    int bad = 0;
    int ack_log[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_data(logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h87;
    endfunction

    assign mem_dato = rd_data(mem_addr);

    psram_arbiter #(
        .ACC_CYC(ACC), .REC_CYC(REC), .STARVE(STV), .ADDR_W(24)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_dati_i(cpu_dati), .cpu_dato_o(cpu_dato), .cpu_ack_o(cpu_ack),
        .mcu_req_i(mcu_req), .mcu_we_i(mcu_we), .mcu_addr_i(mcu_addr),
        .mcu_dati_i(mcu_dati), .mcu_dato_o(mcu_dato), .mcu_ack_o(mcu_ack),
        .mem_addr_o(mem_addr), .mem_dati_o(mem_dati), .mem_dato_i(mem_dato),
        .mem_ce_o(mem_ce), .mem_oe_o(mem_oe), .mem_we_o(mem_we), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accesses as time windows [k, k+ACC) with the next grant
    // allowed no earlier than k+ACC+REC+1; arbitration from the sampled requests.
    int          n = 0, k = 0, next_free = 0, m = 0;
    bit          act = 0, own_mcu = 0, owe = 0;
    logic [23:0] oaddr = '0;
    logic [7:0]  odat = '0, cdato_x = '0, mdato_x = '0;

    always @(posedge clk) begin
        logic creq, mreq, cwe, mwe, gm;
        logic [23:0] ca, ma;
        logic [7:0] cd, md;
        int d;
        creq = cpu_req; mreq = mcu_req; cwe = cpu_we; mwe = mcu_we;
        ca = cpu_addr; ma = mcu_addr; cd = cpu_dati; md = mcu_dati;
        n++;
        if (!rst_n) begin
            act = 0; m = 0; next_free = 0; oaddr = '0; odat = '0;
            cdato_x = '0; mdato_x = '0;
        end else begin
            if (act && (n - k) == ACC && !owe) begin
                if (own_mcu) mdato_x = rd_data(oaddr);
                else         cdato_x = rd_data(oaddr);
            end
            if (!mreq) m = 0;
            if (n >= next_free && (creq || mreq)) begin
                gm = !(creq && !(mreq && m == STV));
                own_mcu = gm;
                owe   = gm ? mwe : cwe;
                oaddr = gm ? ma : ca;
                odat  = gm ? md : cd;
                if (gm) m = 0;
                else if (mreq) m++;
                act = 1; k = n; next_free = n + ACC + REC + 1;
            end
        end
        d = n - k;
        #1;
        check("mem_ce", mem_ce, act && d < ACC);
        check("mem_oe", mem_oe, act && d < ACC && !owe);
        check("mem_we", mem_we, act && owe && d >= 1 && d <= ACC - 2);
        check("busy", busy, act && d < ACC + REC);
        check("cpu_ack", cpu_ack, act && d == ACC && !own_mcu);
        check("mcu_ack", mcu_ack, act && d == ACC && own_mcu);
        check("mem_addr", mem_addr, oaddr);
        check("mem_dati", mem_dati, odat);
        check("cpu_dato", cpu_dato, cdato_x);
        check("mcu_dato", mcu_dato, mdato_x);
        if (cpu_ack) ack_log.push_back(0);
        if (mcu_ack) ack_log.push_back(1);
    end

    task automatic go_idle();
        @(negedge clk);
        cpu_req = 1'b0;
        mcu_req = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_acks(input int target, input int budget);
        int i;
        for (i = 0; i < budget && ack_log.size() < target; i++) @(negedge clk);
        if (ack_log.size() < target) check("ack_timeout", ack_log.size(), target);
    endtask

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cpu_req && cpu_ack)  cpu_req = ($urandom_range(3) == 0);
            else if (cpu_req)        cpu_req = ($urandom_range(15) != 0);
            else                     cpu_req = ($urandom_range(1) == 0);
            if (mcu_req && mcu_ack)  mcu_req = ($urandom_range(3) == 0);
            else if (mcu_req)        mcu_req = ($urandom_range(15) != 0);
            else                     mcu_req = ($urandom_range(2) == 0);
            if ($urandom_range(1) == 1) begin
                cpu_we = 1'($urandom); cpu_addr = 24'($urandom); cpu_dati = 8'($urandom);
            end
            if ($urandom_range(2) == 0) begin
                mcu_we = 1'($urandom); mcu_addr = 24'($urandom); mcu_dati = 8'($urandom);
            end
        end
    endtask

    initial begin
        int base;
        int pat[6];
        pat = '{0, 0, 0, 0, 1, 0};
        repeat (3) @(negedge clk);
        check("rst_ce", mem_ce, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CPU read of 0x000123 returns 0xA5 from the memory model.
        base = ack_log.size();
        cpu_we = 1'b0; cpu_addr = 24'h000123; cpu_req = 1'b1;
        wait_acks(base + 1, 30);
        go_idle();
        check("cpu_rd_dato", cpu_dato, 8'hA5);
        check("cpu_rd_acks", ack_log.size(), base + 1);

        // MCU write.
        base = ack_log.size();
        mcu_we = 1'b1; mcu_addr = 24'h400001; mcu_dati = 8'h3C; mcu_req = 1'b1;
        wait_acks(base + 1, 30);
        go_idle();
        check("mcu_wr_acks", ack_log.size(), base + 1);
        if (ack_log.size() > base) check("mcu_wr_who", ack_log[base], 1);

        // Simultaneous requests: CPU first, then MCU.
        base = ack_log.size();
        cpu_we = 1'b0; mcu_we = 1'b0; cpu_req = 1'b1; mcu_req = 1'b1;
        for (int i = 0; i < 60 && (cpu_req || mcu_req); i++) begin
            @(negedge clk);
            if (cpu_ack) cpu_req = 1'b0;
            if (mcu_ack) mcu_req = 1'b0;
        end
        go_idle();
        check("both_acks", ack_log.size(), base + 2);
        if (ack_log.size() >= base + 2) begin
            check("both_first", ack_log[base], 0);
            check("both_second", ack_log[base + 1], 1);
        end

        // Both held for six grants: CPU x4, MCU, CPU.
        base = ack_log.size();
        cpu_req = 1'b1; mcu_req = 1'b1;
        wait_acks(base + 6, 120);
        go_idle();
        check("starve_acks", ack_log.size(), base + 6);
        for (int i = 0; i < 6; i++)
            if (ack_log.size() > base + i) check("starve_order", ack_log[base + i], pat[i]);

        // Reset at access count 3 drops strobes immediately and issues no ack.
        base = ack_log.size();
        cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("abort_ce", mem_ce, 1'b0);
        check("abort_oe", mem_oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        go_idle();
        check("abort_noack", ack_log.size(), base);

        // Request dropped at access count 1 still completes exactly once.
        base = ack_log.size();
        cpu_we = 1'b1; cpu_addr = 24'h00BEEF; cpu_dati = 8'h5A; cpu_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_addr = 24'h111111;
        repeat (15) @(negedge clk);
        check("drop_acks", ack_log.size(), base + 1);

        run_random(4000);
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
